// File: rtl/data_mem_port.sv
// data_mem_port: byte/half/word load-store responder over a word-wide SRAM, splitting word-crossing accesses
module data_mem_port #(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wEn,
    input  logic [1:0]        req_size,
    input  logic              req_sign,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] ISSUE0 = 3'd1;
    localparam logic [2:0] ISSUE1 = 3'd2;
    localparam logic [2:0] CAPT   = 3'd3;
    localparam logic [2:0] RESP   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic              wen_q, wen_d;
    logic [1:0]        size_q, size_d;
    logic              sign_q, sign_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] word_q, word_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       lo_q, lo_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;

    logic [3:0]        lane_n;
    logic [7:0]        mask;
    logic              split;
    logic [ADDR_W-1:0] word1;
    logic [63:0]       st_wide;
    logic [31:0]       ld_raw;
    logic [31:0]       ld_ext;
    logic              issue0, issue1;
    logic              unused_addr;

    assign unused_addr = ^req_addr[31:ADDR_W+2];

    // Lane mask, second-word address, shifted store data and aligned/extended load data
    always_comb begin
        lane_n  = size_q == 2'b00 ? 4'b0001 : size_q == 2'b01 ? 4'b0011 : 4'b1111;
        mask    = {4'b0000, lane_n} << off_q;
        split   = |mask[7:4];
        word1   = word_q + ADDR_W'(1);
        st_wide = {32'b0, wdata_q} << {off_q, 3'b000};
        ld_raw  = 32'({(split ? mem_rdata : 32'b0), (split ? lo_q : mem_rdata)} >> {off_q, 3'b000});
        ld_ext  = size_q == 2'b00 ? {{24{sign_q & ld_raw[7]}}, ld_raw[7:0]} :
                  size_q == 2'b01 ? {{16{sign_q & ld_raw[15]}}, ld_raw[15:0]} : ld_raw;
    end

    assign issue0     = state_q == ISSUE0;
    assign issue1     = state_q == ISSUE1;
    assign req_ready  = state_q == IDLE;
    assign resp_valid = state_q == RESP;
    assign resp_err   = resp_valid & err_q;
    assign resp_rdata = rdata_q;
    assign mem_en     = issue0 | issue1;
    assign mem_we     = mem_en & wen_q;
    assign mem_addr   = issue0 ? word_q : issue1 ? word1 : '0;
    assign mem_be     = issue0 ? mask[3:0] : issue1 ? mask[7:4] : 4'b0000;
    assign mem_wdata  = issue0 ? st_wide[31:0] : issue1 ? st_wide[63:32] : 32'b0;

    // Request latch and access sequencing; response data is cleared at accept so stores and errors return 0
    always_comb begin
        state_d = state_q;
        wen_d   = wen_q;
        size_d  = size_q;
        sign_d  = sign_q;
        off_d   = off_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        lo_d    = lo_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid) begin
                wen_d   = req_wEn;
                size_d  = req_size;
                sign_d  = req_sign;
                off_d   = req_addr[1:0];
                word_d  = req_addr[ADDR_W+1:2];
                wdata_d = req_wdata;
                err_d   = &req_size;
                rdata_d = 32'b0;
                state_d = &req_size ? RESP : ISSUE0;
            end
            ISSUE0: state_d = split ? ISSUE1 : wen_q ? RESP : CAPT;
            ISSUE1: begin
                lo_d    = mem_rdata;
                state_d = wen_q ? RESP : CAPT;
            end
            CAPT: begin
                rdata_d = ld_ext;
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wen_q   <= 1'b0;
            size_q  <= 2'b00;
            sign_q  <= 1'b0;
            off_q   <= 2'b00;
            word_q  <= '0;
            wdata_q <= 32'b0;
            lo_q    <= 32'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'b0;
        end else begin
            state_q <= state_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            sign_q  <= sign_d;
            off_q   <= off_d;
            word_q  <= word_d;
            wdata_q <= wdata_d;
            lo_q    <= lo_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_data_mem_port.sv
// tb_data_mem_port: directed checks of data_mem_port against an SRAM model
module tb_data_mem_port;
    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_wEn, req_sign;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic        mem_en, mem_we;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, mem_rdata;

    typedef struct packed {
        logic        we;
        logic [13:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } acc_t;

    acc_t        acc_q[$];
    logic [31:0] sram [0:16383];
    int          passed = 0;
    int          total  = 0;

    data_mem_port #(.ADDR_W(14)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wEn(req_wEn),
        .req_size(req_size), .req_sign(req_sign), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clock = ~clock;

    // SRAM model with one-cycle read latency, plus a log of every access strobe
    always @(posedge clock) begin
        if (mem_en) begin
            acc_q.push_back({mem_we, mem_addr, mem_be, mem_wdata});
            if (mem_we) begin
                for (int i = 0; i < 4; i++)
                    if (mem_be[i]) sram[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    function automatic acc_t acc_at(input int i);
        return i < acc_q.size() ? acc_q[i] : '0;
    endfunction

    task automatic do_req(input logic w, input logic [1:0] s, input logic sg,
                          input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic er);
        @(negedge clock);
        acc_q.delete();
        req_valid = 1'b1;
        req_wEn   = w;
        req_size  = s;
        req_sign  = sg;
        req_addr  = a;
        req_wdata = d;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(negedge clock);
            lat++;
        end
        rd = resp_rdata;
        er = resp_err;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; req_valid = 1'b0; req_wEn = 1'b0; req_size = 2'b00;
        req_sign = 1'b0; req_addr = 32'b0; req_wdata = 32'b0;
        repeat (2) @(negedge clock);
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", req_ready); else passed++;
        total++; if ({resp_valid, resp_err} !== 2'b00) $display("FAIL reset_resp got %b want 00", {resp_valid, resp_err}); else passed++;
        total++; if (resp_rdata !== 32'b0) $display("FAIL reset_rdata got %h want 0", resp_rdata); else passed++;
        total++; if ({mem_en, mem_we, mem_addr, mem_be, mem_wdata} !== 52'b0)
            $display("FAIL reset_mem got en=%b we=%b a=%h be=%b d=%h want all 0", mem_en, mem_we, mem_addr, mem_be, mem_wdata); else passed++;
        reset_n = 1'b1;
    endtask

    task automatic test_word;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hDEADBEEF, lat, rd, er);
        total++; if (lat !== 2) $display("FAIL sw_latency got %0d want 2", lat); else passed++;
        total++; if ({rd, er} !== 33'b0) $display("FAIL sw_resp got rdata=%h err=%b want 0/0", rd, er); else passed++;
        total++; if (acc_q.size() !== 1) $display("FAIL sw_count got %0d want 1", acc_q.size()); else passed++;
        total++; if (acc_at(0) !== {1'b1, 14'h40, 4'b1111, 32'hDEADBEEF}) $display("FAIL sw_access got %h want %h", acc_at(0), {1'b1, 14'h40, 4'b1111, 32'hDEADBEEF}); else passed++;
        @(negedge clock);
        total++; if ({resp_valid, req_ready} !== 2'b01) $display("FAIL sw_pulse got valid=%b ready=%b want 0/1", resp_valid, req_ready); else passed++;
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
        total++; if (lat !== 3) $display("FAIL lw_latency got %0d want 3", lat); else passed++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL lw_data got %h want deadbeef", rd); else passed++;
        total++; if (acc_at(0).we !== 1'b0 || acc_at(0).addr !== 14'h40 || acc_at(0).be !== 4'b1111)
            $display("FAIL lw_access got %h want read 040 be 1111", acc_at(0)); else passed++;
    endtask

    task automatic test_byte;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'h80FF7F01, lat, rd, er);
        do_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0, lat, rd, er);
        total++; if (rd !== 32'hFFFFFF80 || lat !== 3) $display("FAIL lb_103 got %h lat %0d want ffffff80 lat 3", rd, lat); else passed++;
        total++; if (acc_at(0).be !== 4'b1000) $display("FAIL lb_be got %b want 1000", acc_at(0).be); else passed++;
        do_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h00000080) $display("FAIL lbu_103 got %h want 00000080", rd); else passed++;
        do_req(1'b0, 2'b00, 1'b1, 32'h101, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h0000007F) $display("FAIL lb_101 got %h want 0000007f", rd); else passed++;
        do_req(1'b0, 2'b01, 1'b1, 32'h102, 32'h0, lat, rd, er);
        total++; if (rd !== 32'hFFFF80FF) $display("FAIL lh_102 got %h want ffff80ff", rd); else passed++;
        do_req(1'b0, 2'b01, 1'b0, 32'h100, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h00007F01) $display("FAIL lhu_100 got %h want 00007f01", rd); else passed++;
    endtask

    task automatic test_split;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b01, 1'b0, 32'h103, 32'h0000A55A, lat, rd, er);
        total++; if (lat !== 3) $display("FAIL sh_split_latency got %0d want 3", lat); else passed++;
        total++; if (acc_q.size() !== 2) $display("FAIL sh_split_count got %0d want 2", acc_q.size()); else passed++;
        total++; if (acc_at(0) !== {1'b1, 14'h40, 4'b1000, 32'h5A000000}) $display("FAIL sh_split_w0 got %h want %h", acc_at(0), {1'b1, 14'h40, 4'b1000, 32'h5A000000}); else passed++;
        total++; if (acc_at(1) !== {1'b1, 14'h41, 4'b0001, 32'h000000A5}) $display("FAIL sh_split_w1 got %h want %h", acc_at(1), {1'b1, 14'h41, 4'b0001, 32'h000000A5}); else passed++;
        total++; if (sram[14'h40] !== 32'h5AFF7F01) $display("FAIL sh_split_sram got %h want 5aff7f01", sram[14'h40]); else passed++;
        do_req(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, lat, rd, er);
        total++; if (rd !== 32'hFFFFA55A || lat !== 4) $display("FAIL lh_split got %h lat %0d want ffffa55a lat 4", rd, lat); else passed++;
        do_req(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h0000A55A) $display("FAIL lhu_split got %h want 0000a55a", rd); else passed++;
    endtask

    task automatic test_wrap;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b10, 1'b0, 32'h0000FFFC, 32'h11223344, lat, rd, er);
        do_req(1'b1, 2'b10, 1'b0, 32'h00000000, 32'h55667788, lat, rd, er);
        do_req(1'b0, 2'b10, 1'b0, 32'h0000FFFE, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h77881122 || lat !== 4) $display("FAIL lw_wrap got %h lat %0d want 77881122 lat 4", rd, lat); else passed++;
        total++; if ({acc_at(0).addr, acc_at(0).be, acc_at(1).addr, acc_at(1).be} !== {14'h3FFF, 4'b1100, 14'h0000, 4'b0011})
            $display("FAIL lw_wrap_access got %h/%b %h/%b want 3fff/1100 0000/0011", acc_at(0).addr, acc_at(0).be, acc_at(1).addr, acc_at(1).be); else passed++;
    endtask

    task automatic test_illegal;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b0, 2'b11, 1'b1, 32'h100, 32'h0, lat, rd, er);
        total++; if (lat !== 1) $display("FAIL illegal_latency got %0d want 1", lat); else passed++;
        total++; if ({er, rd} !== {1'b1, 32'b0}) $display("FAIL illegal_resp got err=%b rdata=%h want 1/0", er, rd); else passed++;
        total++; if (acc_q.size() !== 0) $display("FAIL illegal_no_access got %0d strobes want 0", acc_q.size()); else passed++;
    endtask

    task automatic test_reset_mid;
        int lat; logic [31:0] rd; logic er;
        @(negedge clock);
        req_valid = 1'b1; req_wEn = 1'b0; req_size = 2'b01; req_sign = 1'b1; req_addr = 32'h103;
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        total++; if ({mem_en, mem_addr, mem_be} !== {1'b1, 14'h41, 4'b0001}) $display("FAIL mid_issue1 got en=%b a=%h be=%b want 1/041/0001", mem_en, mem_addr, mem_be); else passed++;
        reset_n = 1'b0;
        #1;
        total++; if ({req_ready, resp_valid, resp_err, mem_en, mem_we, mem_addr, mem_be, mem_wdata, resp_rdata} !== {1'b1, 86'b0})
            $display("FAIL mid_reset got ready=%b valid=%b en=%b a=%h be=%b rdata=%h want reset values", req_ready, resp_valid, mem_en, mem_addr, mem_be, resp_rdata); else passed++;
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        total++; if (req_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", req_ready); else passed++;
        do_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0, lat, rd, er);
        total++; if (rd !== 32'h5AFF7F01 || lat !== 3 || er !== 1'b0) $display("FAIL mid_after_lw got %h lat %0d err %b want 5aff7f01 lat 3 err 0", rd, lat, er); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat; logic [31:0] rd; logic er;
        do_req(1'b1, 2'b00, 1'b0, 32'h202, 32'h000000C3, lat, rd, er);
        total++; if (acc_at(0) !== {1'b1, 14'h80, 4'b0100, 32'h00C30000}) $display("FAIL sb_access got %h want %h", acc_at(0), {1'b1, 14'h80, 4'b0100, 32'h00C30000}); else passed++;
        do_req(1'b0, 2'b00, 1'b1, 32'h202, 32'h0, lat, rd, er);
        total++; if (rd !== 32'hFFFFFFC3 || lat !== 3) $display("FAIL b2b_lb got %h lat %0d want ffffffc3 lat 3", rd, lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_split();
        test_wrap();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired after %0d/%0d checks", passed, total);
        $fatal(1);
    end
endmodule
